// File: rtl/demux1to4_frame.sv
// Frame-collecting 1-to-4 demultiplexer: gathers four words into registered lanes A..D and
// holds them until the consumer takes the frame. Define DEMUX_MANUAL_SEL_EN for S-driven lane selection.
module demux1to4_frame #(
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [N-1:0] D_in,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic         flush,
`ifdef DEMUX_MANUAL_SEL_EN
   input  logic [1:0]   S,
`endif
   output logic [N-1:0] A,
   output logic [N-1:0] B,
   output logic [N-1:0] C,
   output logic [N-1:0] D,
   output logic         frame_valid,
   input  logic         out_ready
);

   typedef enum logic {
      COLLECT = 1'b0,
      HOLD    = 1'b1
   } state_t;

   state_t       state_q;
   logic [N-1:0] lane_q [4];
   logic         frame_valid_q;
   logic [1:0]   sel;
   logic         accept;
   logic         frame_done;

`ifdef DEMUX_MANUAL_SEL_EN
   // Frame completes once every lane has been written at least once, in any order.
   logic [3:0] mask_q, mask_d;
   assign sel        = S;
   assign mask_d     = mask_q | (4'b0001 << S);
   assign frame_done = (mask_d == 4'b1111);
`else
   logic [1:0] cnt_q, cnt_d;
   assign sel        = cnt_q;
   assign cnt_d      = cnt_q + 2'd1;
   assign frame_done = (cnt_q == 2'd3);
`endif

   assign in_ready = (state_q == COLLECT);
   assign accept   = in_valid & in_ready;

   // NOTE: sequential state uses non-blocking assignments only, so every register
   // sees the pre-edge values of the others regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= COLLECT;
         frame_valid_q <= 1'b0;
         // NOTE: the lane array is reset too, because the lanes are visible outputs
         // that must read zero while rst_n is low.
         for (int i = 0; i < 4; i++) lane_q[i] <= '0;
`ifdef DEMUX_MANUAL_SEL_EN
         mask_q <= 4'b0000;
`else
         cnt_q  <= 2'd0;
`endif
      end else if (flush) begin
         state_q       <= COLLECT;
         frame_valid_q <= 1'b0;
`ifdef DEMUX_MANUAL_SEL_EN
         mask_q <= 4'b0000;
`else
         cnt_q  <= 2'd0;
`endif
      end else begin
         unique case (state_q)
            COLLECT: begin
               if (accept) begin
                  lane_q[sel] <= D_in;
`ifdef DEMUX_MANUAL_SEL_EN
                  mask_q <= mask_d;
`else
                  cnt_q  <= cnt_d;
`endif
                  if (frame_done) begin
                     state_q       <= HOLD;
                     frame_valid_q <= 1'b1;
                  end
               end
            end
            HOLD: begin
               if (out_ready) begin
                  state_q       <= COLLECT;
                  frame_valid_q <= 1'b0;
`ifdef DEMUX_MANUAL_SEL_EN
                  mask_q <= 4'b0000;
`endif
               end
            end
            default: begin
               state_q       <= COLLECT;
               frame_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign A           = lane_q[0];
   assign B           = lane_q[1];
   assign C           = lane_q[2];
   assign D           = lane_q[3];
   assign frame_valid = frame_valid_q;

endmodule

// File: tb/tb_demux1to4_frame.sv
// Directed self-checking bench for demux1to4_frame; covers the manual-select build
// when DEMUX_MANUAL_SEL_EN is defined, the automatic build otherwise.
module tb_demux1to4_frame;

   localparam int N = 4;

   logic         clk;
   logic         rst_n;
   logic [N-1:0] D_in;
   logic         in_valid;
   logic         in_ready;
   logic         flush;
   logic [1:0]   S;
   logic [N-1:0] A, B, C, D;
   logic         frame_valid;
   logic         out_ready;

   int checks = 0;
   int errors = 0;

   demux1to4_frame #(.N(N)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .D_in       (D_in),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .flush      (flush),
`ifdef DEMUX_MANUAL_SEL_EN
      .S          (S),
`endif
      .A          (A),
      .B          (B),
      .C          (C),
      .D          (D),
      .frame_valid(frame_valid),
      .out_ready  (out_ready)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Advance one rising edge and settle 1 time unit past it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; D_in = '0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0; S = 2'd0;
      #12;
      checks++;
      if ({A, B, C, D} !== 16'h0000) begin
         errors++; $display("FAIL reset_lanes: got %h expected 0000", {A, B, C, D});
      end
      checks++;
      if (frame_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++; $display("FAIL reset_ctrl: fv=%b rdy=%b expected fv=0 rdy=1", frame_valid, in_ready);
      end
      @(negedge clk);
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_stream();
      logic [N-1:0] words [4] = '{4'h8, 4'h4, 4'h2, 4'h1};
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1; D_in = words[i];
         step();
         if (i == 2) begin
            checks++;
            if (frame_valid !== 1'b0 || in_ready !== 1'b1) begin
               errors++; $display("FAIL stream_early: fv=%b rdy=%b expected fv=0 rdy=1", frame_valid, in_ready);
            end
         end
      end
      in_valid = 1'b0;
      checks++;
      if ({A, B, C, D} !== 16'h8421) begin
         errors++; $display("FAIL stream_lanes: got %h expected 8421", {A, B, C, D});
      end
      checks++;
      if (frame_valid !== 1'b1 || in_ready !== 1'b0) begin
         errors++; $display("FAIL stream_hold: fv=%b rdy=%b expected fv=1 rdy=0", frame_valid, in_ready);
      end
   endtask

   task automatic test_backpressure();
      int bad = 0;
      in_valid = 1'b1; D_in = 4'hF; out_ready = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step();
         if ({A, B, C, D} !== 16'h8421 || frame_valid !== 1'b1) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++; $display("FAIL bp_stable: %0d unstable cycles, expected 0", bad);
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      checks++;
      if (frame_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++; $display("FAIL bp_release: fv=%b rdy=%b expected fv=0 rdy=1", frame_valid, in_ready);
      end
      checks++;
      if ({A, B, C, D} !== 16'h8421) begin
         errors++; $display("FAIL bp_keep: got %h expected 8421", {A, B, C, D});
      end
      D_in = 4'h5;
      step();
      in_valid = 1'b0;
      checks++;
      if ({A, B, C, D} !== 16'h5421) begin
         errors++; $display("FAIL bp_next_in_a: got %h expected 5421", {A, B, C, D});
      end
   endtask

   task automatic test_flush();
      in_valid = 1'b1; D_in = 4'h6;
      step();
      D_in = 4'hC; flush = 1'b1;
      step();
      flush = 1'b0;
      checks++;
      if ({A, B, C, D} !== 16'h5621) begin
         errors++; $display("FAIL flush_drop: got %h expected 5621", {A, B, C, D});
      end
      D_in = 4'hA;
      step();
      in_valid = 1'b0;
      checks++;
      if ({A, B, C, D} !== 16'hA621) begin
         errors++; $display("FAIL flush_restart: got %h expected A621", {A, B, C, D});
      end
   endtask

   task automatic test_gaps();
      logic [N-1:0] words [7] = '{4'h3, 4'hE, 4'h5, 4'hE, 4'h7, 4'hE, 4'h9};
      flush = 1'b1;
      step();
      flush = 1'b0;
      for (int i = 0; i < 7; i++) begin
         in_valid = (i % 2 == 0); D_in = words[i];
         step();
         if (i == 5) begin
            checks++;
            if (frame_valid !== 1'b0 || {A, B, C} !== 12'h357) begin
               errors++; $display("FAIL gaps_partial: fv=%b abc=%h expected fv=0 abc=357", frame_valid, {A, B, C});
            end
         end
      end
      in_valid = 1'b0;
      checks++;
      if ({A, B, C, D} !== 16'h3579 || frame_valid !== 1'b1) begin
         errors++; $display("FAIL gaps_frame: got %h fv=%b expected 3579 fv=1", {A, B, C, D}, frame_valid);
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
   endtask

   task automatic test_async_reset();
      in_valid = 1'b1; D_in = 4'h2;
      step();
      step();
      in_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({A, B, C, D} !== 16'h0000 || frame_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++; $display("FAIL arst_midframe: got %h fv=%b rdy=%b expected 0000 fv=0 rdy=1", {A, B, C, D}, frame_valid, in_ready);
      end
      @(negedge clk);
      rst_n = 1'b1;
`ifdef DEMUX_MANUAL_SEL_EN
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1; D_in = 4'hB; S = 2'(i);
         step();
      end
`else
      in_valid = 1'b1; D_in = 4'hB;
      for (int i = 0; i < 4; i++) step();
`endif
      in_valid = 1'b0;
      checks++;
      if (frame_valid !== 1'b1 || {A, B, C, D} !== 16'hBBBB) begin
         errors++; $display("FAIL arst_prehold: fv=%b got %h expected fv=1 BBBB", frame_valid, {A, B, C, D});
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({A, B, C, D} !== 16'h0000 || frame_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++; $display("FAIL arst_hold: got %h fv=%b rdy=%b expected 0000 fv=0 rdy=1", {A, B, C, D}, frame_valid, in_ready);
      end
      @(negedge clk);
      rst_n = 1'b1;
      step();
   endtask

`ifdef DEMUX_MANUAL_SEL_EN
   task automatic test_manual_sel();
      logic [1:0]   sels  [5] = '{2'd3, 2'd1, 2'd1, 2'd0, 2'd2};
      logic [N-1:0] words [5] = '{4'h1, 4'h2, 4'h9, 4'h3, 4'h4};
      int early = 0;
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1; S = sels[i]; D_in = words[i];
         step();
         if (i < 4 && frame_valid !== 1'b0) early++;
      end
      in_valid = 1'b0;
      checks++;
      if (early != 0) begin
         errors++; $display("FAIL manual_early: fv high in %0d cycles, expected 0", early);
      end
      checks++;
      if ({A, B, C, D} !== 16'h3941 || frame_valid !== 1'b1) begin
         errors++; $display("FAIL manual_frame: got %h fv=%b expected 3941 fv=1", {A, B, C, D}, frame_valid);
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      in_valid = 1'b1; S = 2'd2; D_in = 4'h6;
      step();
      in_valid = 1'b0;
      checks++;
      if (frame_valid !== 1'b0 || C !== 4'h6) begin
         errors++; $display("FAIL manual_mask_clear: fv=%b C=%h expected fv=0 C=6", frame_valid, C);
      end
   endtask
`endif

   initial begin
      test_reset();
`ifdef DEMUX_MANUAL_SEL_EN
      test_manual_sel();
`else
      test_stream();
      test_backpressure();
      test_flush();
      test_gaps();
`endif
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
